// File: rtl/riscv_memory_stage_hs.sv
// riscv_memory_stage_hs
// MEM stage plus MEM/WB register for a RISC-V pipeline, talking to a
// req/gnt/rvalid data bus. Stores finish on grant; loads finish on the rvalid
// that follows the grant. Only one access is outstanding at a time. The pipe
// is held (o_stall_m) until the current access is done.
//
// Optional feature macro: RISCV_MISALIGN_TRAP_EN
//   When defined, a misaligned load/store is not issued on the bus. It
//   completes in one cycle with o_reg_write_w forced low, and the extra output
//   o_misalign_w flags it in the W stage.
//   When undefined, misaligned accesses are issued as they are, and byte
//   lanes that fall past the end of the bus word are dropped.
module riscv_memory_stage_hs #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_m,
  input  logic              i_reg_write_m,
  input  logic [1:0]        i_result_src_m,
  input  logic              i_mem_read_m,
  input  logic              i_mem_write_m,
  input  logic [2:0]        i_funct3_m,
  input  logic [XLEN-1:0]   i_alu_result_m,
  input  logic [XLEN-1:0]   i_write_data_m,
  input  logic [4:0]        i_rd_m,
  input  logic [XLEN-1:0]   i_pc_plus_4m,
  output logic              o_stall_m,
  output logic              o_dbus_req,
  output logic              o_dbus_we,
  output logic [ADDR_W-1:0] o_dbus_addr,
  output logic [XLEN/8-1:0] o_dbus_be,
  output logic [XLEN-1:0]   o_dbus_wdata,
  input  logic              i_dbus_gnt,
  input  logic              i_dbus_rvalid,
  input  logic [XLEN-1:0]   i_dbus_rdata,
  output logic              o_valid_w,
  output logic              o_reg_write_w,
  output logic [1:0]        o_result_src_w,
  output logic [XLEN-1:0]   o_alu_result_w,
  output logic [XLEN-1:0]   o_read_data_w,
  output logic [4:0]        o_rd_w,
`ifdef RISCV_MISALIGN_TRAP_EN
  output logic              o_misalign_w,
`endif
  output logic [XLEN-1:0]   o_pc_plus_4w
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  // Access size codes after funct3 decoding
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              memop;
  logic              trap;
  logic              done;
  logic [1:0]        size;
  logic              uns;
  logic [OFF_W-1:0]  off;
  logic [BE_W-1:0]   mask;
  logic [XLEN-1:0]   load_data;

  // funct3 -> access size; D and WU only exist on a 64-bit datapath, and
  // every code that has no meaning at this width behaves as a word.
  function automatic logic [1:0] decode_size(input logic [2:0] f3);
    logic [1:0] s;
    case (f3)
      3'd0, 3'd4: s = SZ_B;
      3'd1, 3'd5: s = SZ_H;
      3'd2:       s = SZ_W;
      3'd3:       s = (XLEN == 64) ? SZ_D : SZ_W;
      3'd6:       s = SZ_W;
      default:    s = SZ_W;
    endcase
    return s;
  endfunction

  // Zero-extending loads: BU, HU and (64-bit only) WU
  function automatic logic decode_unsigned(input logic [2:0] f3);
    return (f3 == 3'd4) || (f3 == 3'd5) || ((f3 == 3'd6) && (XLEN == 64));
  endfunction

  // Byte-lane mask of an access that starts at lane 0
  function automatic logic [BE_W-1:0] size_mask(input logic [1:0] s);
    logic [BE_W-1:0] m;
    case (s)
      SZ_B:    m = BE_W'(8'h01);
      SZ_H:    m = BE_W'(8'h03);
      SZ_W:    m = BE_W'(8'h0F);
      default: m = BE_W'(8'hFF);
    endcase
    return m;
  endfunction

  // Truncate the lane-shifted bus word to the access size, then extend
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] s,
                                                  input logic [1:0] sz,
                                                  input logic u);
    logic [XLEN-1:0] r;
    case (sz)
      SZ_B: begin
        if (u) r = XLEN'(s[7:0]);
        else   r = XLEN'($signed(s[7:0]));
      end
      SZ_H: begin
        if (u) r = XLEN'(s[15:0]);
        else   r = XLEN'($signed(s[15:0]));
      end
      SZ_W: begin
        if (u) r = XLEN'(s[31:0]);
        else   r = XLEN'($signed(s[31:0]));
      end
      default: r = s;
    endcase
    return r;
  endfunction

`ifdef RISCV_MISALIGN_TRAP_EN
  // Offset bits that must be zero for a naturally aligned access
  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] s);
    logic [OFF_W-1:0] m;
    case (s)
      SZ_B:    m = OFF_W'(3'd0);
      SZ_H:    m = OFF_W'(3'd1);
      SZ_W:    m = OFF_W'(3'd3);
      default: m = OFF_W'(3'd7);
    endcase
    return m;
  endfunction
`endif

  assign memop = i_valid_m & (i_mem_read_m | i_mem_write_m);
  assign size  = decode_size(i_funct3_m);
  assign uns   = decode_unsigned(i_funct3_m);
  assign off   = i_alu_result_m[OFF_W-1:0];
  assign mask  = size_mask(size);

`ifdef RISCV_MISALIGN_TRAP_EN
  assign trap = memop & (|(off & align_mask(size)));
`else
  assign trap = 1'b0;
`endif

  // Bus-side view of the access; all of it follows the MEM inputs, which the
  // stall keeps frozen while the request is waiting for its grant.
  assign o_dbus_we    = i_mem_write_m;
  assign o_dbus_addr  = {i_alu_result_m[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign o_dbus_be    = mask << off;
  assign o_dbus_wdata = i_write_data_m << {off, 3'b000};
  assign load_data    = extend_load(i_dbus_rdata >> {off, 3'b000}, size, uns);

  // Bus FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Bus FSM next state: a load always waits in S_RSP for its data, so rvalid
  // seen in S_IDLE or S_REQ can never be mistaken for a response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (memop && !trap) begin
          if (i_dbus_gnt) state_nxt = i_mem_write_m ? S_IDLE : S_RSP;
          else            state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_dbus_gnt) state_nxt = i_mem_write_m ? S_IDLE : S_RSP;
      end
      S_RSP: begin
        if (i_dbus_rvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus FSM outputs: request, completion of the current access and stall
  always_comb begin
    o_dbus_req = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        o_dbus_req = memop & ~trap;
        done       = memop & (trap | (i_dbus_gnt & i_mem_write_m));
      end
      S_REQ: begin
        o_dbus_req = 1'b1;
        done       = i_dbus_gnt & i_mem_write_m;
      end
      S_RSP: begin
        done = i_dbus_rvalid;
      end
      default: begin
        o_dbus_req = 1'b0;
        done       = 1'b0;
      end
    endcase
    o_stall_m = memop & ~done;
  end

  // MEM/WB register: a bubble while stalled, the whole instruction otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_w      <= 1'b0;
      o_reg_write_w  <= 1'b0;
      o_result_src_w <= 2'b00;
      o_alu_result_w <= '0;
      o_read_data_w  <= '0;
      o_rd_w         <= 5'd0;
      o_pc_plus_4w   <= '0;
`ifdef RISCV_MISALIGN_TRAP_EN
      o_misalign_w   <= 1'b0;
`endif
    end else if (o_stall_m) begin
      o_valid_w      <= 1'b0;
      o_reg_write_w  <= 1'b0;
`ifdef RISCV_MISALIGN_TRAP_EN
      o_misalign_w   <= 1'b0;
`endif
    end else begin
      o_valid_w      <= i_valid_m;
      o_reg_write_w  <= i_valid_m & i_reg_write_m & ~trap;
      o_result_src_w <= i_result_src_m;
      o_alu_result_w <= i_alu_result_m;
      o_read_data_w  <= load_data;
      o_rd_w         <= i_rd_m;
      o_pc_plus_4w   <= i_pc_plus_4m;
`ifdef RISCV_MISALIGN_TRAP_EN
      o_misalign_w   <= trap;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_memory_stage_hs.sv
// Scoreboard bench for riscv_memory_stage_hs: expected bus handshakes and
// expected W-stage results are queued by the stimulus and checked by monitors.
// A 64-bit instance covers the LWU lane/extension case.
module tb_riscv_memory_stage_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // 32-bit instance
  logic        valid_m, reg_write_m, mem_read_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus_4m;
  logic [4:0]  rd_m;
  logic        stall_m, dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        valid_w, reg_write_w;
  logic [1:0]  result_src_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus_4w;
  logic [4:0]  rd_w;
`ifdef RISCV_MISALIGN_TRAP_EN
  logic        misalign_w;
  logic        misalign_w64;
`endif
  // 64-bit instance
  logic        valid64, read64, gnt64, rvalid64;
  logic [2:0]  f3_64;
  logic [63:0] alu64, rdata64;
  logic        stall64, req64, we64, valid_w64, reg_write_w64;
  logic [31:0] addr64;
  logic [7:0]  be64;
  logic [63:0] wdata64, alu_w64, read_w64, pc_w64;
  logic [1:0]  src_w64;
  logic [4:0]  rd_w64;

  riscv_memory_stage_hs #(.XLEN(32), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_m(valid_m), .i_reg_write_m(reg_write_m),
    .i_result_src_m(result_src_m), .i_mem_read_m(mem_read_m), .i_mem_write_m(mem_write_m),
    .i_funct3_m(funct3_m), .i_alu_result_m(alu_result_m), .i_write_data_m(write_data_m),
    .i_rd_m(rd_m), .i_pc_plus_4m(pc_plus_4m), .o_stall_m(stall_m), .o_dbus_req(dbus_req),
    .o_dbus_we(dbus_we), .o_dbus_addr(dbus_addr), .o_dbus_be(dbus_be), .o_dbus_wdata(dbus_wdata),
    .i_dbus_gnt(dbus_gnt), .i_dbus_rvalid(dbus_rvalid), .i_dbus_rdata(dbus_rdata),
    .o_valid_w(valid_w), .o_reg_write_w(reg_write_w), .o_result_src_w(result_src_w),
    .o_alu_result_w(alu_result_w), .o_read_data_w(read_data_w), .o_rd_w(rd_w),
`ifdef RISCV_MISALIGN_TRAP_EN
    .o_misalign_w(misalign_w),
`endif
    .o_pc_plus_4w(pc_plus_4w)
  );

  riscv_memory_stage_hs #(.XLEN(64), .ADDR_W(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid_m(valid64), .i_reg_write_m(1'b1),
    .i_result_src_m(2'b01), .i_mem_read_m(read64), .i_mem_write_m(1'b0),
    .i_funct3_m(f3_64), .i_alu_result_m(alu64), .i_write_data_m(64'd0),
    .i_rd_m(5'd7), .i_pc_plus_4m(64'h2004), .o_stall_m(stall64), .o_dbus_req(req64),
    .o_dbus_we(we64), .o_dbus_addr(addr64), .o_dbus_be(be64), .o_dbus_wdata(wdata64),
    .i_dbus_gnt(gnt64), .i_dbus_rvalid(rvalid64), .i_dbus_rdata(rdata64),
    .o_valid_w(valid_w64), .o_reg_write_w(reg_write_w64), .o_result_src_w(src_w64),
    .o_alu_result_w(alu_w64), .o_read_data_w(read_w64), .o_rd_w(rd_w64),
`ifdef RISCV_MISALIGN_TRAP_EN
    .o_misalign_w(misalign_w64),
`endif
    .o_pc_plus_4w(pc_w64)
  );

  typedef struct {
    logic        reg_write;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        chk_rd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        mis;
  } w_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } b_t;

  w_t wq[$];
  b_t bq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic chk_rd, input logic [4:0] rd,
                        input logic [31:0] pc, input logic mis);
    w_t e;
    e.reg_write = rw; e.src = src; e.alu = alu; e.rdata = rdata;
    e.chk_rd = chk_rd; e.rd = rd; e.pc = pc; e.mis = mis;
    wq.push_back(e);
  endtask

  task automatic push_b(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
    b_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    bq.push_back(e);
  endtask

  // W-stage monitor: every cycle with o_valid_w high retires one instruction
  always @(negedge clk) begin
    if (rst === 1'b0 && valid_w === 1'b1) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL w_unexpected: valid_w=1 alu=%h with no pending expectation", alu_result_w);
      end else begin
        w_t e;
        e = wq.pop_front();
        chk("w_reg_write", reg_write_w, e.reg_write);
        chk("w_result_src", result_src_w, e.src);
        chk("w_alu_result", alu_result_w, e.alu);
        chk("w_rd", rd_w, e.rd);
        chk("w_pc_plus_4", pc_plus_4w, e.pc);
        if (e.chk_rd) chk("w_read_data", read_data_w, e.rdata);
`ifdef RISCV_MISALIGN_TRAP_EN
        chk("w_misalign", misalign_w, e.mis);
`endif
      end
    end
  end

  // Bus monitor: every req&gnt is one accepted access
  always @(negedge clk) begin
    if (rst === 1'b0 && dbus_req === 1'b1 && dbus_gnt === 1'b1) begin
      if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_unexpected: handshake at addr=%h with no pending expectation", dbus_addr);
      end else begin
        b_t e;
        e = bq.pop_front();
        chk("bus_we", dbus_we, e.we);
        chk("bus_addr", dbus_addr, e.addr);
        chk("bus_be", dbus_be, e.be);
        if (e.we) chk("bus_wdata", dbus_wdata, e.wdata);
      end
    end
  end

  // Present one instruction at posedge+1 and play the bus slave until it
  // leaves MEM. gnt_wait = cycles of withheld grant; rvalid follows the grant.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic rw,
                        input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] rdata, input int gnt_wait,
                        output int stalls, output int reqs);
    int   wait_left;
    logic st, rq, g, finished;
    logic [31:0] a0;
    logic [3:0]  be0;
    valid_m = 1'b1; mem_read_m = rd_en; mem_write_m = wr_en; reg_write_m = rw;
    result_src_m = src; funct3_m = f3; alu_result_m = addr; write_data_m = wd;
    rd_m = rd; pc_plus_4m = pc; dbus_rdata = rdata;
    wait_left = gnt_wait; dbus_gnt = (gnt_wait == 0); dbus_rvalid = 1'b0;
    stalls = 0; reqs = 0; finished = 1'b0; a0 = '0; be0 = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      st = stall_m; rq = dbus_req; g = dbus_gnt;
      if (rq) reqs++;
      if (c == 0) begin a0 = dbus_addr; be0 = dbus_be; end
      if (st) begin
        stalls++;
        if (c > 0) chk("stall_bubble_valid_w", valid_w, 1'b0);
      end
      if (c > 0 && rq) begin
        chk("req_addr_stable", dbus_addr, a0);
        chk("req_be_stable", dbus_be, be0);
      end
      @(posedge clk); #1;
      if (!st) begin finished = 1'b1; break; end
      if (rq && g) begin
        dbus_gnt = 1'b0; dbus_rvalid = 1'b1;
      end else if (rq) begin
        wait_left--;
        dbus_gnt = (wait_left == 0);
      end
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL op_timeout: addr=%h never left MEM", addr);
    end
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; reg_write_m = 1'b0;
    dbus_rvalid = 1'b0; dbus_gnt = 1'b1;
  endtask

  int stl, nrq;

  initial begin
    rst = 1'b1;
    valid_m = 0; reg_write_m = 0; mem_read_m = 0; mem_write_m = 0; result_src_m = 0;
    funct3_m = 0; alu_result_m = 0; write_data_m = 0; rd_m = 0; pc_plus_4m = 0;
    dbus_gnt = 1'b1; dbus_rvalid = 1'b0; dbus_rdata = 0;
    valid64 = 0; read64 = 0; gnt64 = 1'b1; rvalid64 = 0; f3_64 = 0; alu64 = 0; rdata64 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_w", valid_w, 1'b0);
    chk("rst_reg_write_w", reg_write_w, 1'b0);
    chk("rst_alu_result_w", alu_result_w, 32'h0);
    chk("rst_read_data_w", read_data_w, 32'h0);
    chk("rst_dbus_req", dbus_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SW 0xDEADBEEF @0x100, grant at once
    push_b(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    push_w(1'b0, 2'd0, 32'h100, 32'h0, 1'b0, 5'd0, 32'h1004, 1'b0);
    run_op(0, 1, 0, 2'd0, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 32'h1004, 32'h0, 0, stl, nrq);
    chk("sw_stalls", stl, 0);

    // LW @0x100
    push_b(1'b0, 32'h100, 4'hF, 32'h0);
    push_w(1'b1, 2'd1, 32'h100, 32'hDEADBEEF, 1'b1, 5'd5, 32'h1008, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd2, 32'h100, 32'h0, 5'd5, 32'h1008, 32'hDEADBEEF, 0, stl, nrq);
    chk("lw_stalls", stl, 1);

    // LB / LBU @0x103, rdata 0x80FFFFFF
    push_b(1'b0, 32'h100, 4'h8, 32'h0);
    push_w(1'b1, 2'd1, 32'h103, 32'hFFFFFF80, 1'b1, 5'd6, 32'h100C, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd0, 32'h103, 32'h0, 5'd6, 32'h100C, 32'h80FFFFFF, 0, stl, nrq);
    push_b(1'b0, 32'h100, 4'h8, 32'h0);
    push_w(1'b1, 2'd1, 32'h103, 32'h00000080, 1'b1, 5'd6, 32'h1010, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd4, 32'h103, 32'h0, 5'd6, 32'h1010, 32'h80FFFFFF, 0, stl, nrq);

    // SH 0x1234 @0x102 with grant withheld 3 cycles
    push_b(1'b1, 32'h100, 4'hC, 32'h12340000);
    push_w(1'b0, 2'd0, 32'h102, 32'h0, 1'b0, 5'd0, 32'h1014, 1'b0);
    run_op(0, 1, 0, 2'd0, 3'd1, 32'h102, 32'h00001234, 5'd0, 32'h1014, 32'h0, 3, stl, nrq);
    chk("sh_gnt_delay_stalls", stl, 3);

    // Non-memory instruction passes straight through
    push_w(1'b1, 2'd0, 32'h55, 32'h0, 1'b0, 5'd3, 32'h1018, 1'b0);
    run_op(0, 0, 1, 2'd0, 3'd0, 32'h55, 32'h0, 5'd3, 32'h1018, 32'h0, 0, stl, nrq);
    chk("alu_stalls", stl, 0);
    chk("alu_no_req", nrq, 0);

    // LH / LHU @0x102, rdata 0x80010000
    push_b(1'b0, 32'h100, 4'hC, 32'h0);
    push_w(1'b1, 2'd1, 32'h102, 32'hFFFF8001, 1'b1, 5'd8, 32'h101C, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd1, 32'h102, 32'h0, 5'd8, 32'h101C, 32'h80010000, 0, stl, nrq);
    push_b(1'b0, 32'h100, 4'hC, 32'h0);
    push_w(1'b1, 2'd1, 32'h102, 32'h00008001, 1'b1, 5'd8, 32'h1020, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd5, 32'h102, 32'h0, 5'd8, 32'h1020, 32'h80010000, 0, stl, nrq);

    // SB of 0x123456AB @0x101: only the low byte, in lane 1
    push_b(1'b1, 32'h100, 4'h2, 32'h3456AB00);
    push_w(1'b0, 2'd0, 32'h101, 32'h0, 1'b0, 5'd0, 32'h1024, 1'b0);
    run_op(0, 1, 0, 2'd0, 3'd0, 32'h101, 32'h123456AB, 5'd0, 32'h1024, 32'h0, 0, stl, nrq);

    // funct3=7 behaves as a word load
    push_b(1'b0, 32'h100, 4'hF, 32'h0);
    push_w(1'b1, 2'd1, 32'h100, 32'h87654321, 1'b1, 5'd9, 32'h1028, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd7, 32'h100, 32'h0, 5'd9, 32'h1028, 32'h87654321, 0, stl, nrq);

    // LW through S_REQ: grant withheld 2 cycles, then one response cycle
    push_b(1'b0, 32'h200, 4'hF, 32'h0);
    push_w(1'b1, 2'd1, 32'h200, 32'h0BADCAFE, 1'b1, 5'd10, 32'h102C, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd2, 32'h200, 32'h0, 5'd10, 32'h102C, 32'h0BADCAFE, 2, stl, nrq);
    chk("lw_gnt_delay_stalls", stl, 3);

    // Misaligned LW @0x101, rdata 0x11223344
`ifdef RISCV_MISALIGN_TRAP_EN
    push_w(1'b0, 2'd1, 32'h101, 32'h0, 1'b0, 5'd11, 32'h1030, 1'b1);
    run_op(1, 0, 1, 2'd1, 3'd2, 32'h101, 32'h0, 5'd11, 32'h1030, 32'h11223344, 0, stl, nrq);
    chk("misalign_stalls", stl, 0);
    chk("misalign_no_req", nrq, 0);
`else
    push_b(1'b0, 32'h100, 4'hE, 32'h0);
    push_w(1'b1, 2'd1, 32'h101, 32'h00112233, 1'b1, 5'd11, 32'h1030, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd2, 32'h101, 32'h0, 5'd11, 32'h1030, 32'h11223344, 0, stl, nrq);
    chk("misalign_stalls", stl, 1);
`endif

    // Reset while waiting in S_RSP; the late rvalid must be ignored
    push_b(1'b0, 32'h100, 4'hF, 32'h0);
    valid_m = 1'b1; mem_read_m = 1'b1; reg_write_m = 1'b1; result_src_m = 2'd1;
    funct3_m = 3'd2; alu_result_m = 32'h100; rd_m = 5'd12; pc_plus_4m = 32'h1034;
    dbus_gnt = 1'b1; dbus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rsp_rst_stall", stall_m, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; valid_m = 1'b0; mem_read_m = 1'b0; reg_write_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; dbus_rvalid = 1'b1;
    @(negedge clk);
    chk("rsp_rst_valid_w", valid_w, 1'b0);
    chk("rsp_rst_req", dbus_req, 1'b0);
    chk("rsp_rst_stall_after", stall_m, 1'b0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0;
    @(negedge clk);
    chk("rsp_rst_no_w_write", valid_w, 1'b0);
    @(posedge clk); #1;

    // Back in S_IDLE: a fresh load takes the normal single stall
    push_b(1'b0, 32'h100, 4'hF, 32'h0);
    push_w(1'b1, 2'd1, 32'h100, 32'h13572468, 1'b1, 5'd13, 32'h1038, 1'b0);
    run_op(1, 0, 1, 2'd1, 3'd2, 32'h100, 32'h0, 5'd13, 32'h1038, 32'h13572468, 0, stl, nrq);
    chk("post_rst_lw_stalls", stl, 1);
    @(posedge clk); #1;

    // 64-bit: LWU @0x104, rdata 0xF000000100000000
    valid64 = 1'b1; read64 = 1'b1; f3_64 = 3'd6; alu64 = 64'h104;
    rdata64 = 64'hF000000100000000; gnt64 = 1'b1;
    @(negedge clk);
    chk("x64_req", req64, 1'b1);
    chk("x64_addr", addr64, 32'h100);
    chk("x64_be", be64, 8'hF0);
    chk("x64_stall", stall64, 1'b1);
    @(posedge clk); #1;
    gnt64 = 1'b0; rvalid64 = 1'b1;
    @(negedge clk);
    chk("x64_req_in_rsp", req64, 1'b0);
    chk("x64_done", stall64, 1'b0);
    @(posedge clk); #1;
    valid64 = 1'b0; read64 = 1'b0; rvalid64 = 1'b0; gnt64 = 1'b1;
    @(negedge clk);
    chk("x64_valid_w", valid_w64, 1'b1);
    chk("x64_lwu_data", read_w64, 64'h00000000F0000001);
    chk("x64_reg_write_w", reg_write_w64, 1'b1);
    chk("x64_rd_w", rd_w64, 5'd7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("w_queue_drained", wq.size(), 0);
    chk("bus_queue_drained", bq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
